restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 113 +++++++++++
 tb/tb_restoring_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first.
// Latency n+1 edges from accepted start to done (1 edge when divisor is zero); start is ignored while not IDLE.
module restoring_divider #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  dvs_q, dvs_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [n:0]    r_sh;
  logic [n:0]    trial;
  logic          carry;
  logic          take;

  // quo_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    r_sh           = {rem_q, quo_q[n-1]};
    {carry, trial} = {1'b0, r_sh} + {1'b0, ~{1'b0, dvs_q}} + {{(n+1){1'b0}}, 1'b1};
    // A carry implies trial < divisor, so trial[n] is always clear when taken.
    take           = carry & ~trial[n];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = dividend;
            rem_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = take ? trial[n-1:0] : r_sh[n-1:0];
        quo_d = {quo_q[n-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(n - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: directed cases, abort/ignore cases, then random operands.
module tb_restoring_divider;
  localparam int N = 32;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  restoring_divider #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // inj_cyc: RUN cycle at which a stray start with new operands is driven (0 = none).
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input int inj_cyc, input bit hold);
    exp_t e;
    int   edges;
    int   busy_n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start  = 1'b0;
    edges  = 1;
    busy_n = 0;
    while (!done && edges < N + 10) begin
      if (busy) busy_n++;
      if (inj_cyc != 0 && edges == inj_cyc) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else if (inj_cyc != 0 && edges == inj_cyc + 1) begin
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
      edges++;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(edges), (b == '0) ? 32'd1 : 32'(N + 1));
    chk("busy_cycles", 32'(busy_n), (b == '0) ? 32'd0 : 32'(N));
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    if (hold) begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("hold_quotient", quotient, e.q);
      chk("hold_remainder", remainder, e.r);
    end
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    logic [N-1:0] a;
    logic [N-1:0] b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 0, 1'b1);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 1'b1);
    run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1'b1);
    run_div(32'd55, 32'd0, 0, 1'b1);
    run_div(32'd100, 32'd7, 10, 1'b1);

    // Idle with start low: results must not move even as operands wander.
    dividend = 32'd1234;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    chk("idle_quotient", quotient, 32'd14);
    chk("idle_remainder", remainder, 32'd2);
    chk("idle_done", 32'(done), 32'd0);

    // Abort at RUN cycle 16.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("no_done_after_abort", 32'(done_seen), 32'd0);
    chk("start_in_rst_ignored", 32'(busy_seen), 32'd0);
    run_div(32'd9, 32'd3, 0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = $urandom >> $urandom_range(0, 31);
      else b = 32'($urandom_range(1, 1000));
      run_div(a, b, 0, (i % 50) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
